mem_wb_stage: RTL and testbench

//  Memory/write-back stage: consumes alu_signals bundle registered by the ALU stage, runs any

---
 rtl/cpu_pkg.sv | 33 +++
 rtl/mem_lane_steer.sv | 25 ++
 rtl/mem_wb_stage.sv | 147 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU-stage result bundle, memory/write-back FSM states
// and the memory access size codes carried in mem_read / mem_write.
package cpu_pkg;

    localparam int CPU_ADDR_W = 24;

    // Access size codes; 2'b11 is treated as a word access as well.
    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef struct packed {
        logic [15:0]           data_out;
        logic [1:0]            reg_write;
        logic [3:0]            reg_dest;
        logic                  setPC;
        logic [1:0]            mem_read;
        logic [1:0]            mem_write;
        logic [CPU_ADDR_W-1:0] mem_addr;
    } alu_signals;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC1 = 2'd1,
        ACC2 = 2'd2,
        WB   = 2'd3
    } mws_state_t;

    function automatic logic size_is_word(input logic [1:0] sz);
        return sz[1];
    endfunction

endpackage

// File: rtl/mem_lane_steer.sv
// Lane steering for the 16-bit little-endian bus: byte enables, replicated
// write data and extraction of the addressed byte from the read data.
module mem_lane_steer (
    input  logic        a0,
    input  logic        word,
    input  logic [15:0] wsrc,
    input  logic [15:0] rdata,
    output logic [1:0]  be,
    output logic [15:0] wdata,
    output logic [15:0] rval
);

    // Word accesses use both lanes as-is; byte accesses select the lane by a0.
    always_comb begin
        be    = 2'b11;
        wdata = wsrc;
        rval  = rdata;
        if (!word) begin
            be    = a0 ? 2'b10 : 2'b01;
            wdata = {wsrc[7:0], wsrc[7:0]};
            rval  = {8'h00, (a0 ? rdata[15:8] : rdata[7:0])};
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory / write-back stage. Latches the ALU bundle on en, performs up to two
// bus cycles (odd-address words split into two byte cycles), then pulses the
// register-file and PC write strobes together with done.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 24,  // 17..CPU_ADDR_W
    parameter bit SPLIT_MISAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  alu_signals        ctl_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              busy,
    output logic              done,
    output logic              bus_req,
    output logic              bus_we,
    output logic [1:0]        bus_be,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [15:0]       bus_wdata,
    input  logic [15:0]       bus_rdata,
    input  logic              bus_ack,
    output logic [1:0]        rf_we,
    output logic [3:0]        rf_reg,
    output logic [15:0]       rf_data,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_value
);

    localparam int PCH_W = ADDR_W - 16;

    mws_state_t        state_q, state_d;
    alu_signals        ctl_q, ctl_d;
    logic [PCH_W-1:0]  pch_q, pch_d;
    logic [15:0]       rd_q, rd_d;

    logic              is_rd, is_wr, is_word, split, lane_word, in_mem;
    logic [1:0]        sz;
    logic [ADDR_W-1:0] addr_a, cyc_addr;
    logic [15:0]       wsrc;
    logic [1:0]        lane_be;
    logic [15:0]       lane_wdata, lane_rval;

    // Only the upper PC bits feed pc_value; the low half is replaced by data.
    logic unused_pc_lo;
    assign unused_pc_lo = ^pc_in[15:0];

    // Decode the latched bundle and the address of the current bus cycle.
    always_comb begin
        is_rd     = |ctl_q.mem_read;
        is_wr     = !is_rd && (|ctl_q.mem_write);
        sz        = is_rd ? ctl_q.mem_read : ctl_q.mem_write;
        is_word   = size_is_word(sz);
        addr_a    = ctl_q.mem_addr[ADDR_W-1:0];
        split     = SPLIT_MISAL && is_word && addr_a[0];
        lane_word = is_word && !split;
        cyc_addr  = (state_q == ACC2) ? addr_a + {{(ADDR_W-1){1'b0}}, 1'b1} : addr_a;
        wsrc      = (state_q == ACC2) ? {8'h00, ctl_q.data_out[15:8]} : ctl_q.data_out;
        in_mem    = (|ctl_in.mem_read) || (|ctl_in.mem_write);
    end

    mem_lane_steer u_steer (
        .a0    (lane_word ? 1'b0 : cyc_addr[0]),
        .word  (lane_word),
        .wsrc  (wsrc),
        .rdata (bus_rdata),
        .be    (lane_be),
        .wdata (lane_wdata),
        .rval  (lane_rval)
    );

    // Next-state logic: accept en in IDLE, advance bus cycles on ack, collect read bytes.
    always_comb begin
        state_d = state_q;
        ctl_d   = ctl_q;
        pch_d   = pch_q;
        rd_d    = rd_q;
        unique case (state_q)
            IDLE: begin
                if (en) begin
                    ctl_d   = ctl_in;
                    pch_d   = pc_in[ADDR_W-1:16];
                    rd_d    = 16'h0000;
                    state_d = in_mem ? ACC1 : WB;
                end
            end
            ACC1: begin
                if (bus_ack) begin
                    if (is_rd) rd_d = lane_rval;
                    state_d = split ? ACC2 : WB;
                end
            end
            ACC2: begin
                if (bus_ack) begin
                    if (is_rd) rd_d[15:8] = lane_rval[7:0];
                    state_d = WB;
                end
            end
            WB: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and bundle registers; reset drops any bus cycle immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctl_q   <= '0;
            pch_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctl_d;
            pch_q   <= pch_d;
            rd_q    <= rd_d;
        end
    end

    // Bus outputs: driven only while a request is outstanding, zero otherwise.
    always_comb begin
        bus_req   = (state_q == ACC1) || (state_q == ACC2);
        bus_we    = bus_req && is_wr;
        bus_be    = bus_req ? lane_be : 2'b00;
        bus_addr  = bus_req ? {cyc_addr[ADDR_W-1:1], 1'b0} : '0;
        bus_wdata = bus_we ? lane_wdata : 16'h0000;
    end

    // Write-back outputs: valid only in the single WB cycle.
    always_comb begin
        busy     = (state_q != IDLE);
        done     = (state_q == WB);
        rf_we    = 2'b00;
        rf_reg   = 4'h0;
        rf_data  = 16'h0000;
        pc_we    = 1'b0;
        pc_value = '0;
        if (done) begin
            rf_we    = is_rd ? (is_word ? 2'b11 : 2'b01) : ctl_q.reg_write;
            rf_reg   = ctl_q.reg_dest;
            rf_data  = is_rd ? rd_q : ctl_q.data_out;
            pc_we    = ctl_q.setPC;
            pc_value = {pch_q, ctl_q.data_out};
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: directed vector table, reset/overlap sequences
// and randomized transactions checked against a byte-addressed memory model.
module tb_mem_wb_stage;
    import cpu_pkg::*;

    localparam int AW = 24;
    localparam logic [23:0] AMASK = 24'hFFFFFF;

    logic          clk, rst_n, en;
    alu_signals    ctl_in;
    logic [AW-1:0] pc_in;
    logic          busy, done, bus_req, bus_we, bus_ack;
    logic [1:0]    bus_be, rf_we;
    logic [AW-1:0] bus_addr, pc_value;
    logic [15:0]   bus_wdata, bus_rdata, rf_data;
    logic [3:0]    rf_reg;
    logic          pc_we;

    mem_wb_stage #(.ADDR_W(AW), .SPLIT_MISAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .ctl_in(ctl_in), .pc_in(pc_in),
        .busy(busy), .done(done), .bus_req(bus_req), .bus_we(bus_we),
        .bus_be(bus_be), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .rf_we(rf_we),
        .rf_reg(rf_reg), .rf_data(rf_data), .pc_we(pc_we), .pc_value(pc_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Byte-addressed memory seen by the bus responder; unknown bytes get random contents.
    logic [7:0] mem [int];

    function automatic logic [7:0] mrd(input logic [23:0] a);
        if (!mem.exists(int'(a))) mem[int'(a)] = 8'($urandom);
        return mem[int'(a)];
    endfunction

    // Observations of one transaction.
    int          obs_n, o_lat;
    bit          o_done;
    logic [23:0] obs_addr [2];
    logic [1:0]  obs_be [2];
    logic        obs_we [2];
    logic [15:0] obs_wd [2];
    logic [1:0]  o_rf_we;
    logic [3:0]  o_rf_reg;
    logic [15:0] o_rf_data;
    logic        o_pc_we;
    logic [23:0] o_pc_val;

    // Called at a falling edge; drives en, answers bus cycles after dly idle cycles,
    // optionally pokes en while busy and/or a stray ack in the en cycle.
    task automatic run_txn(input alu_signals c, input logic [23:0] pc, input int dly,
                           input bit stray, input bit poke);
        int cnt;
        bit in_cyc, poked;
        obs_n = 0; o_done = 0; in_cyc = 0; poked = 0; cnt = 0; o_lat = 0;
        en = 1'b1; ctl_in = c; pc_in = pc; bus_ack = stray; bus_rdata = 16'h0000;
        @(negedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            en = 1'b0; bus_ack = 1'b0;
            if (done) begin
                o_done = 1; o_lat = cyc;
                o_rf_we = rf_we; o_rf_reg = rf_reg; o_rf_data = rf_data;
                o_pc_we = pc_we; o_pc_val = pc_value;
                chk("busy_at_done", 32'(busy), 32'd1);
                break;
            end
            if (bus_req) begin
                if (!in_cyc) begin
                    if (obs_n < 2) begin
                        obs_addr[obs_n] = bus_addr; obs_be[obs_n] = bus_be;
                        obs_we[obs_n] = bus_we;     obs_wd[obs_n] = bus_wdata;
                    end
                    obs_n++; in_cyc = 1; cnt = dly;
                end else if (obs_n <= 2) begin
                    chk("bus_stable", {bus_addr, bus_be, bus_we, 5'd0},
                        {obs_addr[obs_n-1], obs_be[obs_n-1], obs_we[obs_n-1], 5'd0});
                end
                if (cnt == 0) begin
                    bus_ack = 1'b1;
                    bus_rdata = {mrd(bus_addr | 24'h1), mrd(bus_addr)};
                    if (bus_we) begin
                        if (bus_be[0]) mem[int'(bus_addr)] = bus_wdata[7:0];
                        if (bus_be[1]) mem[int'(bus_addr | 24'h1)] = bus_wdata[15:8];
                    end
                    in_cyc = 0;
                end else begin
                    cnt--;
                    if (poke && !poked) begin
                        en = 1'b1; ctl_in = ~c; poked = 1;
                    end
                end
            end
            @(negedge clk);
        end
        en = 1'b0; bus_ack = 1'b0;
        chk("done_seen", 32'(o_done), 32'd1);
        if (o_done) begin
            @(negedge clk);
            chk("done_pulse", 32'(done), 32'd0);
            chk("busy_fall", 32'(busy), 32'd0);
        end
    endtask

    function automatic alu_signals mkc(input logic [15:0] d, input logic [1:0] rw,
                                       input logic [3:0] dest, input logic spc,
                                       input logic [1:0] mr, input logic [1:0] mw,
                                       input logic [23:0] a);
        alu_signals s;
        s.data_out = d; s.reg_write = rw; s.reg_dest = dest; s.setPC = spc;
        s.mem_read = mr; s.mem_write = mw; s.mem_addr = a;
        return s;
    endfunction

    typedef struct {
        alu_signals  c;
        logic [23:0] pc;
        int          dly;
        bit          stray, poke, pre;
        logic [23:0] pre_a;
        logic [15:0] pre_w;
        int          ncyc;
        logic [23:0] a1; logic [1:0] be1; logic [15:0] wd1;
        logic [23:0] a2; logic [1:0] be2; logic [15:0] wd2;
        logic        we;
        logic [1:0]  rfwe; logic [3:0] rfreg; logic [15:0] rfdata;
        logic        pcwe; logic [23:0] pcval;
    } vec_t;

    vec_t vt [8];

    initial begin
        rst_n = 1'b0; en = 1'b0; ctl_in = '0; pc_in = '0; bus_ack = 1'b0; bus_rdata = 16'h0000;

        vt[0] = '{mkc(16'h1234,2'b11,4'd3,1'b0,2'b00,2'b00,24'h0), 24'h0, 0, 1,0,0, 24'h0, 16'h0,
                  0, 24'h0,2'b00,16'h0, 24'h0,2'b00,16'h0, 1'b0, 2'b11,4'd3,16'h1234, 1'b0,24'h001234};
        vt[1] = '{mkc(16'h0000,2'b00,4'd5,1'b0,2'b01,2'b00,24'h000101), 24'h0, 3, 0,0,1, 24'h000100, 16'hAB55,
                  1, 24'h000100,2'b10,16'h0, 24'h0,2'b00,16'h0, 1'b0, 2'b01,4'd5,16'h00AB, 1'b0,24'h000000};
        vt[2] = '{mkc(16'hBEEF,2'b00,4'd7,1'b0,2'b00,2'b10,24'h000203), 24'h0, 1, 0,1,0, 24'h0, 16'h0,
                  2, 24'h000202,2'b10,16'hEFEF, 24'h000204,2'b01,16'hBEBE, 1'b1, 2'b00,4'd7,16'hBEEF, 1'b0,24'h00BEEF};
        vt[3] = '{mkc(16'h0000,2'b00,4'd2,1'b0,2'b10,2'b00,24'hFFFFFF), 24'h0, 2, 0,0,1, 24'hFFFFFF, 16'h2211,
                  2, 24'hFFFFFE,2'b10,16'h0, 24'h000000,2'b01,16'h0, 1'b0, 2'b11,4'd2,16'h2211, 1'b0,24'h000000};
        vt[4] = '{mkc(16'h4000,2'b00,4'd0,1'b1,2'b00,2'b00,24'h0), 24'h120010, 0, 0,0,0, 24'h0, 16'h0,
                  0, 24'h0,2'b00,16'h0, 24'h0,2'b00,16'h0, 1'b0, 2'b00,4'd0,16'h4000, 1'b1,24'h124000};
        vt[5] = '{mkc(16'h0000,2'b01,4'd9,1'b0,2'b10,2'b00,24'h000400), 24'h0, 0, 0,0,1, 24'h000400, 16'hCAFE,
                  1, 24'h000400,2'b11,16'h0, 24'h0,2'b00,16'h0, 1'b0, 2'b11,4'd9,16'hCAFE, 1'b0,24'h000000};
        vt[6] = '{mkc(16'h12A5,2'b01,4'd4,1'b1,2'b00,2'b01,24'h000300), 24'h345678, 0, 0,0,0, 24'h0, 16'h0,
                  1, 24'h000300,2'b01,16'hA5A5, 24'h0,2'b00,16'h0, 1'b1, 2'b01,4'd4,16'h12A5, 1'b1,24'h3412A5};
        vt[7] = '{mkc(16'h5555,2'b00,4'd1,1'b0,2'b01,2'b10,24'h000501), 24'h0, 1, 0,0,1, 24'h000500, 16'h7700,
                  1, 24'h000500,2'b10,16'h0, 24'h0,2'b00,16'h0, 1'b0, 2'b01,4'd1,16'h0077, 1'b0,24'h005555};

        // Reset state
        #3;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);
        chk("rst_outs", {8'(bus_addr), rf_data, 8'(pc_value)}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            if (vt[i].pre) begin
                mem[int'(vt[i].pre_a)] = vt[i].pre_w[7:0];
                mem[int'((vt[i].pre_a + 24'h1) & AMASK)] = vt[i].pre_w[15:8];
            end
            run_txn(vt[i].c, vt[i].pc, vt[i].dly, vt[i].stray, vt[i].poke);
            chk($sformatf("v%0d_ncyc", i), 32'(obs_n), 32'(vt[i].ncyc));
            chk($sformatf("v%0d_latency", i), 32'(o_lat), 32'(1 + vt[i].ncyc * (vt[i].dly + 1)));
            if (vt[i].ncyc >= 1 && obs_n >= 1) begin
                chk($sformatf("v%0d_addr1", i), 32'(obs_addr[0]), 32'(vt[i].a1));
                chk($sformatf("v%0d_be1", i), 32'(obs_be[0]), 32'(vt[i].be1));
                chk($sformatf("v%0d_we1", i), 32'(obs_we[0]), 32'(vt[i].we));
                if (vt[i].we) chk($sformatf("v%0d_wd1", i), 32'(obs_wd[0]), 32'(vt[i].wd1));
            end
            if (vt[i].ncyc == 2 && obs_n >= 2) begin
                chk($sformatf("v%0d_addr2", i), 32'(obs_addr[1]), 32'(vt[i].a2));
                chk($sformatf("v%0d_be2", i), 32'(obs_be[1]), 32'(vt[i].be2));
                if (vt[i].we) chk($sformatf("v%0d_wd2", i), 32'(obs_wd[1]), 32'(vt[i].wd2));
            end
            chk($sformatf("v%0d_rf_we", i), 32'(o_rf_we), 32'(vt[i].rfwe));
            chk($sformatf("v%0d_rf_reg", i), 32'(o_rf_reg), 32'(vt[i].rfreg));
            chk($sformatf("v%0d_rf_data", i), 32'(o_rf_data), 32'(vt[i].rfdata));
            chk($sformatf("v%0d_pc_we", i), 32'(o_pc_we), 32'(vt[i].pcwe));
            chk($sformatf("v%0d_pc_value", i), 32'(o_pc_val), 32'(vt[i].pcval));
        end

        // Reset while a bus cycle waits for ack
        en = 1'b1; ctl_in = mkc(16'h0, 2'b00, 4'd6, 1'b1, 2'b01, 2'b00, 24'h000010); pc_in = 24'h0;
        @(negedge clk);
        en = 1'b0;
        chk("mid_req_up", 32'(bus_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_wb", {30'd0, rf_we} | 32'(done) | 32'(pc_we), 32'd0);
        @(negedge clk);
        chk("mid_rst_nodone", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_txn(mkc(16'h9A9A, 2'b10, 4'd8, 1'b0, 2'b00, 2'b00, 24'h0), 24'h0, 0, 0, 0);
        chk("post_rst_rf_we", 32'(o_rf_we), 32'd2);
        chk("post_rst_rf_data", 32'(o_rf_data), 32'h9A9A);

        // Randomized transactions against the memory model
        for (int t = 0; t < 150; t++) begin
            alu_signals  c;
            logic [23:0] a, pc;
            logic [1:0]  szc;
            logic [15:0] exp_rd;
            int          kind, dly, ncyc;
            bit          rd, wr, word;
            kind = $urandom_range(0, 3);
            szc  = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 4))
                0: a = 24'hFFFFFF;
                1: a = 24'hFFFFFE;
                2: a = 24'h000000;
                default: a = 24'($urandom);
            endcase
            pc = 24'($urandom);
            c = mkc(16'($urandom), 2'($urandom), 4'($urandom), 1'($urandom),
                    (kind == 1 || kind == 3) ? szc : 2'b00,
                    (kind == 2 || kind == 3) ? 2'($urandom_range(1, 3)) : 2'b00, a);
            rd   = (c.mem_read != 2'b00);
            wr   = !rd && (c.mem_write != 2'b00);
            word = rd ? (c.mem_read >= 2'b10) : (c.mem_write >= 2'b10);
            ncyc = (rd || wr) ? ((word && a[0]) ? 2 : 1) : 0;
            exp_rd = word ? {mrd((a + 24'h1) & AMASK), mrd(a)} : {8'h00, mrd(a)};
            dly = $urandom_range(0, 3);
            run_txn(c, pc, dly, 1'($urandom), 1'($urandom));
            chk("r_ncyc", 32'(obs_n), 32'(ncyc));
            chk("r_latency", 32'(o_lat), 32'(1 + ncyc * (dly + 1)));
            chk("r_rf_we", 32'(o_rf_we), rd ? (word ? 32'd3 : 32'd1) : 32'(c.reg_write));
            chk("r_rf_reg", 32'(o_rf_reg), 32'(c.reg_dest));
            chk("r_rf_data", 32'(o_rf_data), rd ? 32'(exp_rd) : 32'(c.data_out));
            chk("r_pc_we", 32'(o_pc_we), 32'(c.setPC));
            chk("r_pc_value", 32'(o_pc_val), {8'd0, pc[23:16], c.data_out});
            if (wr) begin
                chk("r_mem_lo", 32'(mrd(a)), 32'(c.data_out[7:0]));
                if (word) chk("r_mem_hi", 32'(mrd((a + 24'h1) & AMASK)), 32'(c.data_out[15:8]));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
